// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- MIPS memory stage
//
// Registers the EX-stage result and runs at most one data-bus transaction per
// instruction. Loads get byte-lane selection plus sign/zero extension; stores
// get byte strobes and lane-replicated write data. Upstream is stalled
// (in_ready=0) from acceptance until the result has been handed to writeback.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses skip the bus, raise exc_adel or
//               exc_ades for the out_valid cycle and clear the regwrite bit.
//   undefined : exc_* are constant 0; misaligned half uses o[1] only, and
//               misaligned word ignores the offset.
//
// Ports
//   clk, resetn                      clock (rising) / async active-low reset
//   in_valid, in_ready               EX -> MEM handshake
//   control_e, rd_e, alu_e, wdata_e  instruction payload from EX
//   mem_read, mem_write, mem_size,
//   mem_unsigned                     memory op decode (size 0 B, 1 H, 2/3 W)
//   flush                            kill the instruction currently held
//   dreq_valid/addr/strobe/data      data-bus request (held stable in REQ)
//   daddr_ok, ddata_ok, ddata        data-bus request accept / response
//   out_valid, controlM, rdM,
//   ALUoutM, ReadDataM               result to writeback (one cycle each)
//   exc_adel, exc_ades               misaligned load / store exceptions
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int CTRL_W = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_e,
    input  logic [4:0]        rd_e,
    input  logic [31:0]       alu_e,
    input  logic [31:0]       wdata_e,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [3:0]        dreq_strobe,
    output logic [31:0]       dreq_data,
    input  logic              daddr_ok,
    input  logic              ddata_ok,
    input  logic [31:0]       ddata,
    output logic              out_valid,
    output logic [CTRL_W-1:0] controlM,
    output logic [4:0]        rdM,
    output logic [31:0]       ALUoutM,
    output logic [31:0]       ReadDataM,
    output logic              exc_adel,
    output logic              exc_ades
);

    localparam int REGWRITE_BIT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Instruction captured at acceptance (stage 1 of the memory stage)
    logic [CTRL_W-1:0] ctrl_p1;
    logic [4:0]        rd_p1;
    logic [31:0]       alu_p1;
    logic [31:0]       wdata_p1;
    logic              ld_p1;
    logic              st_p1;
    logic [1:0]        size_p1;
    logic              uns_p1;
    logic              adel_p1;
    logic              ades_p1;
    logic              killed_p1;
    logic [31:0]       rdata_p1;

    logic mis_e;
    logic accept;
    logic capture;
    logic is_load_e;
    logic is_store_e;

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------
    function automatic logic [31:0] load_ext(input logic [1:0]  size,
                                             input logic        uns,
                                             input logic [1:0]  o,
                                             input logic [31:0] d);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = d[8*o +: 8];
        h = o[1] ? d[31:16] : d[15:0];
        case (size)
            2'd0:    load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_ext = d;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size,
                                                input logic [1:0] o);
        case (size)
            2'd0:    store_strobe = 4'b0001 << o;
            2'd1:    store_strobe = o[1] ? 4'b1100 : 4'b0011;
            default: store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0]  size,
                                               input logic [31:0] w);
        case (size)
            2'd0:    store_data = {4{w[7:0]}};
            2'd1:    store_data = {2{w[15:0]}};
            default: store_data = w;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Alignment check on the incoming effective address
    // -------------------------------------------------------------------------
`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        case (mem_size)
            2'd0:    mis_e = 1'b0;
            2'd1:    mis_e = alu_e[0];
            default: mis_e = |alu_e[1:0];
        endcase
    end
`else
    assign mis_e = 1'b0;
`endif

    // A write with mem_read also set is handled as a load.
    assign is_load_e  = mem_read;
    assign is_store_e = mem_write & ~mem_read;
    assign accept     = (state_q == IDLE) && in_valid && !flush;
    assign capture    = ((state_q == REQ) && daddr_ok && ddata_ok) ||
                        ((state_q == WAIT) && ddata_ok);

    // -------------------------------------------------------------------------
    // State register and captured payload
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ctrl_p1   <= '0;
            rd_p1     <= '0;
            alu_p1    <= '0;
            wdata_p1  <= '0;
            ld_p1     <= 1'b0;
            st_p1     <= 1'b0;
            size_p1   <= '0;
            uns_p1    <= 1'b0;
            adel_p1   <= 1'b0;
            ades_p1   <= 1'b0;
            killed_p1 <= 1'b0;
            rdata_p1  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ctrl_p1   <= control_e;
                rd_p1     <= rd_e;
                alu_p1    <= alu_e;
                wdata_p1  <= wdata_e;
                ld_p1     <= is_load_e;
                st_p1     <= is_store_e;
                size_p1   <= mem_size;
                uns_p1    <= mem_unsigned;
                adel_p1   <= is_load_e & mis_e;
                ades_p1   <= is_store_e & mis_e;
                killed_p1 <= 1'b0;
                rdata_p1  <= '0;
            end
            // Once the bus has taken the request it cannot be recalled, so a
            // flush only marks the instruction dead until its response drains.
            if (((state_q == REQ) && daddr_ok && flush) ||
                ((state_q == WAIT) && flush)) begin
                killed_p1 <= 1'b1;
            end
            if (capture && ld_p1) begin
                rdata_p1 <= load_ext(size_p1, uns_p1, alu_p1[1:0], ddata);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((is_load_e || is_store_e) && !mis_e) state_d = REQ;
                    else                                      state_d = DONE;
                end
            end
            REQ: begin
                if (daddr_ok) begin
                    if (ddata_ok) state_d = flush ? IDLE : DONE;
                    else          state_d = WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (ddata_ok) state_d = (killed_p1 || flush) ? IDLE : DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus request and writeback outputs
    // -------------------------------------------------------------------------
    assign in_ready    = (state_q == IDLE);
    assign dreq_valid  = (state_q == REQ);
    assign dreq_addr   = {alu_p1[ADDR_W-1:2], 2'b00};
    assign dreq_strobe = st_p1 ? store_strobe(size_p1, alu_p1[1:0]) : 4'b0000;
    assign dreq_data   = store_data(size_p1, wdata_p1);

    assign out_valid = (state_q == DONE);
    assign rdM       = rd_p1;
    assign ALUoutM   = alu_p1;
    assign ReadDataM = (ld_p1 && !adel_p1) ? rdata_p1 : 32'd0;
    assign exc_adel  = out_valid & adel_p1;
    assign exc_ades  = out_valid & ades_p1;

    // A faulting access must not write the register file.
    always_comb begin
        controlM = '0;
        if (out_valid) begin
            controlM = ctrl_p1;
            if (adel_p1 || ades_p1) controlM[REGWRITE_BIT] = 1'b0;
        end
    end

endmodule
